mnist_pixel_packer: RTL
=======================

# mnist_pixel_packer

Upstream feeder for the 121-32-10 TCB classifier top. Accepts an 11×11 greyscale image as a serial stream of 8-bit pixels and packs it into the classifier's 968-bit `img_source` word. Presents the packed word to the classifier with a valid/ready handshake. Optionally double-buffers, so the next frame streams in while the classifier still holds the current one.

## Interface
Parameters:
- `PIX_W`, 8: bits per pixel.
- `N_PIX`, 121: pixels per frame.
- `IMG_W` (localparam) = `N_PIX*PIX_W` = 968.
- `CNT_W`, 16: width of the frame counter.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `pix_in`, in, `PIX_W`: pixel data.
- `pix_valid`, in, 1: `pix_in` is valid.
- `pix_last`, in, 1: qualifies the last pixel of a frame.
- `pix_ready`, out, 1: packer can accept a pixel.
- `img_source`, out, `IMG_W`: packed image, connects to the classifier `img_source`.
- `valid_top`, out, 1: `img_source` holds a complete frame.
- `ready_top`, in, 1: classifier accepts the frame.
- `frame_err`, out, 1: one-cycle pulse when a frame is dropped.
- `frame_cnt`, out, `CNT_W`: count of frames handed over; wraps to 0.

## Operation
- Pixel beat = `pix_valid && pix_ready`. Frame beat = `valid_top && ready_top`.
- Pixel index `idx` runs 0..120 and is held in a 7-bit counter.
- Pixel k lands in `fill[IMG_W-1-k*PIX_W -: PIX_W]`: first pixel in MSBs [967:960], pixel 120 in [7:0].
- Fill states: `FILL` and `FULL`.
- FILL:
  - Each pixel beat writes one pixel and increments `idx`.
  - Beat with `idx==120` (with or without `pix_last`) completes the frame and resets `idx` to 0.
- Early `pix_last` (on a beat with `idx<120`):
  - Frame discarded, `idx` reset to 0, `frame_err` pulses next cycle.
  - That pixel is not kept.
- Frame completion without double buffering:
  - `fill` copies to `img_source`, `valid_top` goes 1, state goes to FULL.
  - `pix_ready` = 0 while FULL.
- Frame beat: `valid_top` drops (unless a buffered frame is pending), `frame_cnt` increments, state returns to FILL.
- `img_source` holds its value unchanged while `valid_top && !ready_top`. It is not cleared after handover.
- `frame_cnt` wraps from `2^CNT_W-1` to 0.

## Timing
- Reset values: `img_source` = 0, `valid_top` = 0, `pix_ready` = 0 during reset and 1 on the first cycle after release, `frame_err` = 0, `frame_cnt` = 0, `idx` = 0, state FILL.
- Latency: the 121st pixel beat at edge N gives `valid_top` = 1 after edge N. Minimum frame period is 121 cycles plus 1 handover cycle without double buffering.
- `pix_ready` is registered and does not depend combinationally on `pix_valid`.
- Frame beat at edge M: `valid_top` = 0 and `pix_ready` = 1 after edge M, when no buffered frame is pending.
- `ready_top` asserted while `valid_top` = 0: ignored.
- Reset mid-frame: partial frame is lost and all state returns to reset values immediately.

## Configuration
- Macro `MNIST_PACK_DBUF_EN`.
- Defined: a second `IMG_W` holding register (shadow) is added.
  - Completing a frame while `valid_top` = 1 and no frame beat occurs: the frame goes to the shadow. `pix_ready` = 0 only while output and shadow are both full.
  - Frame beat with shadow full: shadow moves to `img_source`, `valid_top` stays 1, `pix_ready` returns to 1.
  - Frame completion in the same cycle as a frame beat with shadow empty: the new frame goes directly to `img_source` and `valid_top` stays 1.
  - Handover order is always FIFO.
- Undefined: single buffer, behaviour exactly as in Operation.

## Test plan
- Reset, then 121 pixels with `pix_in` = k (k = 0..120), `pix_last` on the last, `ready_top` = 1 → `valid_top` = 1 for one cycle, `img_source[967:960]` = 0x00, `img_source[7:0]` = 0x78, `frame_cnt` = 1.
- Hold `ready_top` = 0 for 50 cycles after frame completion → `img_source` stable and `pix_ready` = 0 (undefined macro); raising `ready_top` → handover, then `pix_ready` = 1 after the next edge.
- `pix_last` on the pixel with `idx` = 40 → one-cycle `frame_err` = 1, no `valid_top`; the next 121 pixels (all 0xAA) form a clean frame equal to 121 repetitions of 0xAA.
- Assert `rst` at `idx` = 60 → all outputs at reset values; the following full frame packs correctly from `idx` = 0.
- Macro defined, `ready_top` = 0: stream three frames of constant 0x11, 0x22, 0x33 → `pix_ready` drops after frame 2; on releasing `ready_top`, the bench sees 0x11, then 0x22, then 0x33 in order, with `frame_cnt` = 3.
- Preload `frame_cnt` to 0xFFFF by 65535 handovers (or force) → the next handover gives `frame_cnt` = 0.

Source files
------------

// File: rtl/mnist_pixel_packer.sv
// mnist_pixel_packer
//   Packs an 11x11 greyscale image, streamed one 8-bit pixel per beat, into
//   the 968-bit img_source word of the 121-32-10 classifier.
//   Pixel k occupies img_source[IMG_W-1-k*PIX_W -: PIX_W], so the first pixel
//   sits in the MSBs. The frame goes to the classifier over valid_top/ready_top.
//
//   Build option: define MNIST_PACK_DBUF_EN to add a shadow frame register.
//   The next frame can then stream in while the classifier still holds the
//   current one. Handover order stays FIFO.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   pix_in     in   pixel data (PIX_W)
//   pix_valid  in   pix_in valid
//   pix_last   in   marks the last pixel of a frame
//   pix_ready  out  registered; packer accepts a pixel
//   img_source out  packed frame (IMG_W)
//   valid_top  out  img_source holds a complete frame
//   ready_top  in   classifier takes the frame
//   frame_err  out  one-cycle pulse when a frame is dropped (early pix_last)
//   frame_cnt  out  frames handed over, wraps to 0 (CNT_W)
module mnist_pixel_packer #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned N_PIX = 121,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned IMG_W = N_PIX * PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             pix_last,
    output logic             pix_ready,
    output logic [IMG_W-1:0] img_source,
    output logic             valid_top,
    input  logic             ready_top,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int unsigned        IDX_W    = $clog2(N_PIX);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_PIX - 1);

    typedef enum logic {FILL, FULL} state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [IMG_W-1:0] fill, fill_n;
    logic [IMG_W-1:0] img_n;
    logic             valid_n;
    logic             ready_n;
    logic             err_n;
    logic [CNT_W-1:0] cnt_n;
    logic             pix_beat, frame_beat, at_last, complete, early;
`ifdef MNIST_PACK_DBUF_EN
    logic [IMG_W-1:0] shadow, shadow_n;
    logic             shadow_vld, shadow_vld_n;
    logic             out_free;
`endif

    always_comb begin
        pix_beat   = pix_valid && pix_ready;
        frame_beat = valid_top && ready_top;
        at_last    = (idx == LAST_IDX);
        complete   = pix_beat && at_last;
        // pix_last before the final index drops the frame, pixel included
        early      = pix_beat && pix_last && !at_last;

        state_n = state;
        idx_n   = idx;
        fill_n  = fill;
        img_n   = img_source;
        valid_n = valid_top;
        cnt_n   = frame_cnt;
        err_n   = early;

        // fill_n includes the current pixel so a completing beat copies a whole frame
        if (pix_beat && !early)
            fill_n[IMG_W - PIX_W - PIX_W * 32'(idx) +: PIX_W] = pix_in;

        if (complete || early)
            idx_n = '0;
        else if (pix_beat)
            idx_n = idx + IDX_W'(1);

        if (frame_beat)
            cnt_n = frame_cnt + CNT_W'(1);

`ifdef MNIST_PACK_DBUF_EN
        shadow_n     = shadow;
        shadow_vld_n = shadow_vld;

        if (frame_beat) begin
            if (shadow_vld) begin
                img_n        = shadow;
                shadow_vld_n = 1'b0;
            end else if (!complete) begin
                valid_n = 1'b0;
            end
        end

        // A new frame goes straight to the output only if nothing is queued
        // ahead of it. Otherwise it waits in the shadow.
        out_free = !valid_top || (frame_beat && !shadow_vld);
        if (complete) begin
            if (out_free) begin
                img_n   = fill_n;
                valid_n = 1'b1;
            end else begin
                shadow_n     = fill_n;
                shadow_vld_n = 1'b1;
            end
        end

        // FULL means output and shadow are both occupied
        case (state)
            FILL:    if (complete && valid_top && !frame_beat) state_n = FULL;
            FULL:    if (frame_beat) state_n = FILL;
            default: state_n = FILL;
        endcase
`else
        if (frame_beat)
            valid_n = 1'b0;
        if (complete) begin
            img_n   = fill_n;
            valid_n = 1'b1;
        end

        case (state)
            FILL:    if (complete) state_n = FULL;
            FULL:    if (frame_beat) state_n = FILL;
            default: state_n = FILL;
        endcase
`endif

        ready_n = (state_n == FILL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            idx        <= '0;
            fill       <= '0;
            img_source <= '0;
            valid_top  <= 1'b0;
            pix_ready  <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
`ifdef MNIST_PACK_DBUF_EN
            shadow     <= '0;
            shadow_vld <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            fill       <= fill_n;
            img_source <= img_n;
            valid_top  <= valid_n;
            pix_ready  <= ready_n;
            frame_err  <= err_n;
            frame_cnt  <= cnt_n;
`ifdef MNIST_PACK_DBUF_EN
            shadow     <= shadow_n;
            shadow_vld <= shadow_vld_n;
`endif
        end
    end

endmodule
